pwm_meas: RTL and testbench

Input-side counterpart to the board's divided-clock/PWM LED drivers: measures the period and high time of an external square/PWM signal in system-clock cycles. Sits between a board input pin and status/debug logic, for example an LED indicator or UART report. Reports one measurement per input cycle with a single-cycle valid strobe. Flags a stalled input after a configurable timeout.

---
 rtl/pwm_meas_pkg.sv | 19 +
 rtl/pwm_meas_if.sv | 30 +++
 rtl/pwm_meas_sig_sync_edge.sv | 73 +++++++
 rtl/pwm_meas.sv | 141 ++++++++++++++
 tb/tb_pwm_meas.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_meas_pkg.sv
// pwm_meas_pkg: shared types and board defaults for the PWM/period meter.
//   state_t          measurement FSM states
//   CNT_W_DEF        default counter/output width
//   TIMEOUT_CYC_DEF  default stall timeout (1 s at the 12 MHz board clock)
//   FILT_LEN_DEF     default glitch-filter stability length
package pwm_meas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } state_t;

  localparam int unsigned CNT_W_DEF       = 24;
  localparam int unsigned TIMEOUT_CYC_DEF = 12_000_000;
  localparam int unsigned FILT_LEN_DEF    = 4;

endpackage

// File: rtl/pwm_meas_if.sv
// pwm_meas_if: signal bundle between the PWM meter and its surroundings.
//   sig_in     input signal under measurement (asynchronous)
//   meas_en    measurement enable, level
//   period     cycles between the last two rising edges
//   high_time  cycles from the last rising edge to the following falling edge
//   valid      one-cycle strobe when period/high_time update
//   stall      input stuck longer than the timeout
//   busy       meter is not idle
// Modports: master drives sig_in/meas_en, slave (the meter) drives the rest.
interface pwm_meas_if #(
  parameter int unsigned CNT_W = 24
);
  logic             sig_in;
  logic             meas_en;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             stall;
  logic             busy;

  modport master (
    output sig_in, meas_en,
    input  period, high_time, valid, stall, busy
  );

  modport slave (
    input  sig_in, meas_en,
    output period, high_time, valid, stall, busy
  );
endinterface

// File: rtl/pwm_meas_sig_sync_edge.sv
// sig_sync_edge: two-flop synchronizer, optional stability filter and edge
// detector for the PWM meter input.
//   clk, rst  system clock, asynchronous active-high reset
//   sig_in    raw asynchronous input
//   level     synchronized (and filtered) level
//   rise      one-cycle pulse on a 0->1 change of level
//   fall      one-cycle pulse on a 1->0 change of level
// Build option PWM_MEAS_GLITCH_FILTER_EN: level only follows the synchronized
// input after it has held a new value for FILT_LEN consecutive cycles, adding
// FILT_LEN cycles of latency to both edges. Without it FILT_LEN is unused and
// edges appear 3 cycles after an input transition.
module sig_sync_edge #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  if (FILT_LEN < 1) begin : g_filt_len_check
    $error("sig_sync_edge: FILT_LEN must be at least 1");
  end

  logic s1, s2;
  logic lvl_q;
  logic lvl_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
    end
  end

`ifdef PWM_MEAS_GLITCH_FILTER_EN
  localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  // stab counts consecutive cycles the synced input disagrees with lvl_q
  logic [FW-1:0] stab;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= 1'b0;
      stab  <= '0;
    end else if (s2 == lvl_q) begin
      stab <= '0;
    end else if (stab == FW'(FILT_LEN - 1)) begin
      lvl_q <= s2;
      stab  <= '0;
    end else begin
      stab <= stab + FW'(1);
    end
  end
`else
  always_comb lvl_q = s2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_prev <= 1'b0;
    else     lvl_prev <= lvl_q;
  end

  assign level = lvl_q;
  assign rise  = lvl_q & ~lvl_prev;
  assign fall  = ~lvl_q & lvl_prev;

endmodule

// File: rtl/pwm_meas.sv
// pwm_meas: measures period and high time of an external PWM/square signal
// in system-clock cycles and flags a stalled input.
//   clk, rst  system clock, asynchronous active-high reset
//   bus       pwm_meas_if.slave: sig_in, meas_en in; period, high_time,
//             valid, stall, busy out
// Parameters: CNT_W (counter/output width), TIMEOUT_CYC (stall timeout in
// cycles, < 2^CNT_W), FILT_LEN (glitch filter length).
// Build option PWM_MEAS_GLITCH_FILTER_EN enables the input glitch filter in
// sig_sync_edge.
module pwm_meas
  import pwm_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned FILT_LEN    = FILT_LEN_DEF
) (
  input logic       clk,
  input logic       rst,
  pwm_meas_if.slave bus
);

  if (64'(TIMEOUT_CYC) >= (64'd1 << CNT_W)) begin : g_timeout_check
    $error("pwm_meas: TIMEOUT_CYC must be below 2^CNT_W");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

  logic sig_level, rise, fall;

  sig_sync_edge #(
    .FILT_LEN (FILT_LEN)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (bus.sig_in),
    .level  (sig_level),
    .rise   (rise),
    .fall   (fall)
  );

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             stall_q, stall_d;
  logic             valid_q, valid_d;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      period_q <= '0;
      high_q   <= '0;
      shadow_q <= '0;
      stall_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      shadow_q <= shadow_d;
      stall_q  <= stall_d;
      valid_q  <= valid_d;
    end
  end

  // Edge events take priority over the timeout check in HIGH/LOW.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    period_d = period_q;
    high_d   = high_q;
    shadow_d = shadow_q;
    stall_d  = stall_q;
    valid_d  = 1'b0;

    if (state != IDLE && !bus.meas_en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_d = '0;
          if (bus.meas_en) state_d = ARM;
        end
        ARM: begin
          if (rise) begin
            state_d = HIGH;
            cnt_d   = CNT_W'(1);
          end
        end
        HIGH: begin
          if (rise) begin
            // unexpected second rise: restart the high phase, nothing reported
            cnt_d = CNT_W'(1);
          end else if (fall) begin
            shadow_d = cnt;
            state_d  = LOW;
            cnt_d    = cnt_inc;
          end else if (cnt == TIMEOUT_V) begin
            stall_d = 1'b1;
            state_d = ARM;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            period_d = cnt;
            high_d   = shadow_q;
            valid_d  = 1'b1;
            stall_d  = 1'b0;
            cnt_d    = CNT_W'(1);
            state_d  = HIGH;
          end else if (cnt == TIMEOUT_V) begin
            stall_d = 1'b1;
            state_d = ARM;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_q;
  assign bus.valid     = valid_q;
  assign bus.stall     = stall_q;
  assign bus.busy      = (state != IDLE);

  a_edges_exclusive: assert property (@(posedge clk) disable iff (rst) !(rise && fall));
  a_rise_level:      assert property (@(posedge clk) disable iff (rst) rise |-> sig_level);
  a_fall_level:      assert property (@(posedge clk) disable iff (rst) fall |-> !sig_level);

endmodule

// File: tb/tb_pwm_meas.sv
// tb_pwm_meas: self-checking bench for pwm_meas. A timestamp-based model
// derives the expected outputs from input edge times; a compare process checks
// every cycle, and directed scenarios add literal expectations.
module tb_pwm_meas;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned FILT    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pwm_meas_if #(.CNT_W(CNT_W)) bus ();

  pwm_meas #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT),
    .FILT_LEN    (FILT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Edge index e counts clock edges since reset. An input change first
  // sampled at edge m is acted on at edge m+2 (3 cycles after the transition),
  // or m+3 once the filter has seen FILT stable samples.
  int  e;
  int  t_rise, t_fall;
  bit  m_active, exp_valid, exp_stall;
  int  exp_period, exp_high;
  bit  prev_s, flvl;
  int  run;
  bit  ev_r[16], ev_f[16];

  initial begin : model
    bit x, en, r, f;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        e = 0; t_rise = -1; t_fall = -1;
        m_active = 0; exp_valid = 0; exp_stall = 0;
        exp_period = 0; exp_high = 0;
        prev_s = 0; flvl = 0; run = 0;
        for (int i = 0; i < 16; i++) begin ev_r[i] = 0; ev_f[i] = 0; end
      end else begin
        x  = bus.sig_in;
        en = bus.meas_en;
`ifdef PWM_MEAS_GLITCH_FILTER_EN
        if (x != flvl) run++; else run = 0;
        if (run == FILT) begin
          flvl = x; run = 0;
          if (x) ev_r[(e + 3) % 16] = 1; else ev_f[(e + 3) % 16] = 1;
        end
`else
        if (x != prev_s) begin
          if (x) ev_r[(e + 2) % 16] = 1; else ev_f[(e + 2) % 16] = 1;
          prev_s = x;
        end
`endif
        r = ev_r[e % 16]; f = ev_f[e % 16];
        ev_r[e % 16] = 0; ev_f[e % 16] = 0;
        exp_valid = 0;
        if (!en) begin
          m_active = 0; t_rise = -1; t_fall = -1;
        end else if (!m_active) begin
          m_active = 1;
        end else if (r) begin
          if (t_rise >= 0 && t_fall > t_rise) begin
            exp_period = e - t_rise;
            exp_high   = t_fall - t_rise;
            exp_valid  = 1;
            exp_stall  = 0;
          end
          t_rise = e; t_fall = -1;
        end else if (f) begin
          if (t_rise >= 0) t_fall = e;
        end else if (t_rise >= 0 && e - t_rise == int'(TIMEOUT)) begin
          exp_stall = 1; t_rise = -1; t_fall = -1;
        end
        e++;
      end
    end
  end

  // ---------------- compare + monitor ----------------
  int  vcnt;
  int  last_p, last_h, last_valid_e, stall_e;
  bit  stall_prev;

  initial begin : compare
    vcnt = 0; last_p = 0; last_h = 0; last_valid_e = 0; stall_e = 0; stall_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("valid",     32'(bus.valid),     32'(exp_valid));
        chk("stall",     32'(bus.stall),     32'(exp_stall));
        chk("busy",      32'(bus.busy),      32'(m_active));
        chk("period",    32'(bus.period),    32'(exp_period));
        chk("high_time", 32'(bus.high_time), 32'(exp_high));
        if (bus.valid === 1'b1) begin
          vcnt++;
          last_p = int'(bus.period);
          last_h = int'(bus.high_time);
          last_valid_e = e;
        end
        if (bus.stall === 1'b1 && !stall_prev) stall_e = e;
        stall_prev = (bus.stall === 1'b1);
      end else begin
        stall_prev = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v);
    bus.sig_in = v;
    tick();
  endtask

  task automatic pwm(input int per, input int hi, input int n);
    for (int c = 0; c < n; c++)
      for (int p = 0; p < per; p++)
        drive(p < hi);
  endtask

  initial begin : stim
    bus.sig_in  = 1'b0;
    bus.meas_en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    bus.meas_en = 1'b1;
    tick();
    chk("busy_after_first_reset", 32'(bus.busy), 32'd1);
    repeat (5) drive(1'b0);

    // steady PWM 100/25: first rise only arms
    vcnt = 0;
    pwm(100, 25, 5);
    chk("steady_valid_count", 32'(vcnt), 32'd4);
    chk("steady_period", 32'(last_p), 32'd100);
    chk("steady_high", 32'(last_h), 32'd25);

    // duty change to 75/100
    vcnt = 0;
    pwm(100, 75, 3);
    chk("duty_valid_count", 32'(vcnt), 32'd3);
    chk("duty_period", 32'(last_p), 32'd100);
    chk("duty_high", 32'(last_h), 32'd75);

    // timeout: input parked low after a 100/25 measurement
    pwm(100, 25, 2);
    repeat (1100) drive(1'b0);
    chk("timeout_stall", 32'(bus.stall), 32'd1);
    chk("timeout_hold_period", 32'(bus.period), 32'd100);
    chk("timeout_hold_high", 32'(bus.high_time), 32'd25);
    chk("timeout_distance", 32'(stall_e - last_valid_e), 32'd1000);

    // restart at 200/50
    vcnt = 0;
    pwm(200, 50, 3);
    chk("restart_valid_count", 32'(vcnt), 32'd2);
    chk("restart_stall_clear", 32'(bus.stall), 32'd0);
    chk("restart_period", 32'(last_p), 32'd200);
    chk("restart_high", 32'(last_h), 32'd50);

    // enable drop during HIGH
    pwm(100, 25, 2);
    repeat (10) drive(1'b1);
    bus.meas_en = 1'b0;
    drive(1'b1);
    chk("disable_busy", 32'(bus.busy), 32'd0);
    chk("disable_valid", 32'(bus.valid), 32'd0);
    repeat (14) drive(1'b1);
    repeat (75) drive(1'b0);
    bus.meas_en = 1'b1;
    repeat (20) drive(1'b0);
    vcnt = 0;
    pwm(100, 40, 3);
    chk("reenable_valid_count", 32'(vcnt), 32'd2);
    chk("reenable_period", 32'(last_p), 32'd100);
    chk("reenable_high", 32'(last_h), 32'd40);

    // reset in the middle of a LOW phase
    for (int p = 0; p < 43; p++) drive(p < 25);
    rst = 1'b1;
    #1;
    chk("reset_period", 32'(bus.period), 32'd0);
    chk("reset_high", 32'(bus.high_time), 32'd0);
    chk("reset_valid", 32'(bus.valid), 32'd0);
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    bus.sig_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("busy_after_reset", 32'(bus.busy), 32'd1);
    repeat (5) drive(1'b0);

`ifdef PWM_MEAS_GLITCH_FILTER_EN
    // 100/30 with a 2-cycle low glitch inside the high phase
    vcnt = 0;
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < 100; p++)
        drive((p < 30) && !(p == 10 || p == 11));
    chk("glitch_valid_count", 32'(vcnt), 32'd2);
    chk("glitch_period", 32'(last_p), 32'd100);
    chk("glitch_high", 32'(last_h), 32'd30);
`endif

    repeat (10) drive(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
